// File: rtl/tap_sequencer_if.sv
// Bundle between tap_sequencer, the sample memory read port and the downstream stream consumer.
// "slave" is the sequencer side and "master" is the environment side.
interface tap_sequencer_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic [ADDR_W-1:0] count;
    logic              oldest_first;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [WIDTH-1:0]  mem_data;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, count, oldest_first, mem_data, out_ready,
        output mem_addr, mem_read, out_data, out_valid, out_last, busy, done
    );

    modport master (
        output start, count, oldest_first, mem_data, out_ready,
        input  mem_addr, mem_read, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/tap_sequencer.sv
// Read-side sequencer for the shift-register sample memory.
// It issues a READ/CAPT/HOLD cycle per word and streams the words out with a last flag.
module tap_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LENGTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    tap_sequencer_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(LENGTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              oldest_q, oldest_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] n_c;
    logic              last_c;

    // Effective length: a request longer than the memory is clamped to its depth.
    assign n_c = (bus.count > ADDR_W'(LENGTH)) ? ADDR_W'(LENGTH) : bus.count;

    // The word now in CAPT is the final one when the index has reached the end of its walk.
    assign last_c = oldest_q ? (index_q == '0) : (index_q == len_q - ADDR_W'(1));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            len_q       <= '0;
            oldest_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            len_q       <= len_d;
            oldest_q    <= oldest_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = (n_c != '0) ? READ : DONE;
            READ: state_d = CAPT;
            CAPT: state_d = HOLD;
            HOLD: if (bus.out_ready) state_d = out_last_q ? DONE : READ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the index/length registers.
    always_comb begin
        index_d     = index_q;
        len_d       = len_q;
        oldest_d    = oldest_q;
        mem_addr_d  = mem_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (n_c != '0)) begin
                    len_d    = n_c;
                    oldest_d = bus.oldest_first;
                    index_d  = bus.oldest_first ? (n_c - ADDR_W'(1)) : '0;
                end
            end
            CAPT: begin
                out_data_d  = bus.mem_data;
                out_valid_d = 1'b1;
                out_last_d  = last_c;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (!out_last_q)
                        index_d = oldest_q ? (index_q - ADDR_W'(1)) : (index_q + ADDR_W'(1));
                end
            end
            default: ;
        endcase
        mem_read_d = (state_d == READ);
        if (state_d == READ) mem_addr_d = index_d;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer with a behavioural shift-register sample memory.
module tb_tap_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tap_sequencer_if #(.WIDTH(16), .ADDR_W(7)) bus ();
    tap_sequencer #(.WIDTH(16), .LENGTH(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [15:0] mem [64];
    logic [6:0]  addr_log [$];
    logic [15:0] got_d [$];
    logic        got_l [$];
    int          got_c [$];

    // Registered-read sample memory and bus observers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_read) begin
            addr_log.push_back(bus.mem_addr);
            bus.mem_data <= mem[bus.mem_addr[5:0]];
        end
        if (bus.done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [15:0] v);
        for (int i = 63; i > 0; i--) mem[i] = mem[i-1];
        mem[0] = v;
    endtask

    task automatic load_abcd();
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        shift_in(16'h000A); shift_in(16'h000B); shift_in(16'h000C); shift_in(16'h000D);
    endtask

    task automatic start_xfer(input logic [6:0] cnt, input logic oldest);
        bus.start = 1'b1; bus.count = cnt; bus.oldest_first = oldest;
        tick();
        bus.start = 1'b0;
    endtask

    // Records every handshake until n words are seen or the cycle budget expires.
    task automatic collect(input int n, input int budget);
        int c = 0;
        got_d.delete(); got_l.delete(); got_c.delete();
        while (got_d.size() < n && c < budget) begin
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                got_c.push_back(cyc);
            end
            tick();
            c++;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int c = 0;
        while (!bus.out_valid && c < budget) begin tick(); c++; end
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus.mem_addr !== 7'd0)  begin n_fail++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
        n_checks++; if (bus.mem_read !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
        n_checks++; if (bus.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_newest();
        logic [15:0] exp_d [4] = '{16'h000D, 16'h000C, 16'h000B, 16'h000A};
        logic        exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0]  exp_a [4] = '{7'd0, 7'd1, 7'd2, 7'd3};
        load_abcd(); addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        start_xfer(7'd4, 1'b0);
        n_checks++; if (bus.mem_read !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL newest_first_read: got read=%b busy=%b expected 1 1", bus.mem_read, bus.busy); end
        tick();
        n_checks++; if (bus.mem_read !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL newest_capt: got read=%b valid=%b expected 0 0", bus.mem_read, bus.out_valid); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL newest_valid_latency: got %b expected 1", bus.out_valid); end
        collect(4, 40);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL newest_done_after_last: got %b expected 1", bus.done); end
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL newest_done_width: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
        n_checks++; if (got_d.size() != 4 || addr_log.size() != 4) begin n_fail++; $display("FAIL newest_counts: got words=%0d reads=%0d expected 4 4", got_d.size(), addr_log.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                begin n_fail++; $display("FAIL newest_word[%0d]: got %h/%b expected %h/%b", i, (i < got_d.size()) ? got_d[i] : 16'hxxxx, (i < got_l.size()) ? got_l[i] : 1'bx, exp_d[i], exp_l[i]); end
            n_checks++;
            if (i >= addr_log.size() || addr_log[i] !== exp_a[i])
                begin n_fail++; $display("FAIL newest_addr[%0d]: got %0d expected %0d", i, (i < addr_log.size()) ? addr_log[i] : 7'h7f, exp_a[i]); end
        end
        n_checks++; if (got_c.size() < 2 || got_c[1] - got_c[0] != 3) begin n_fail++; $display("FAIL newest_rate: got spacing %0d expected 3", (got_c.size() < 2) ? -1 : got_c[1] - got_c[0]); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL newest_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_oldest();
        logic [15:0] exp_d [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        logic        exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [6:0]  exp_a [4] = '{7'd3, 7'd2, 7'd1, 7'd0};
        load_abcd(); addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        start_xfer(7'd4, 1'b1);
        collect(4, 40);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
                begin n_fail++; $display("FAIL oldest_word[%0d]: got %h/%b expected %h/%b", i, (i < got_d.size()) ? got_d[i] : 16'hxxxx, (i < got_l.size()) ? got_l[i] : 1'bx, exp_d[i], exp_l[i]); end
            n_checks++;
            if (i >= addr_log.size() || addr_log[i] !== exp_a[i])
                begin n_fail++; $display("FAIL oldest_addr[%0d]: got %0d expected %0d", i, (i < addr_log.size()) ? addr_log[i] : 7'h7f, exp_a[i]); end
        end
        n_checks++; if (done_cnt != 1 || addr_log.size() != 4) begin n_fail++; $display("FAIL oldest_counts: got done=%0d reads=%0d expected 1 4", done_cnt, addr_log.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        load_abcd(); addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        start_xfer(7'd3, 1'b0);
        wait_valid(10, ok);
        n_checks++; if (!ok || bus.out_data !== 16'h000D) begin n_fail++; $display("FAIL stall_word0: got %h expected 000D", bus.out_data); end
        tick();
        bus.out_ready = 1'b0;
        wait_valid(10, ok);
        n_checks++; if (!ok || bus.out_data !== 16'h000C) begin n_fail++; $display("FAIL stall_word1: got %h expected 000C", bus.out_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h000C || bus.mem_read !== 1'b0 || bus.out_last !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
        bus.out_ready = 1'b1;
        collect(2, 20);
        tick(); tick();
        n_checks++; if (got_d.size() != 2 || got_d[0] !== 16'h000C || got_d[1] !== 16'h000B || got_l[1] !== 1'b1)
            begin n_fail++; $display("FAIL stall_tail: got %0d words expected 000C then 000B(last)", got_d.size()); end
        n_checks++; if (addr_log.size() != 3 || done_cnt != 1) begin n_fail++; $display("FAIL stall_counts: got reads=%0d done=%0d expected 3 1", addr_log.size(), done_cnt); end
    endtask

    task automatic test_zero_and_clamp();
        addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        start_xfer(7'd0, 1'b0);
        n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL zero_done: got busy=%b done=%b read=%b expected 1 1 0", bus.busy, bus.done, bus.mem_read); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        n_checks++; if (addr_log.size() != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_reads: got reads=%0d done=%0d expected 0 1", addr_log.size(), done_cnt); end
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        addr_log.delete(); done_cnt = 0;
        start_xfer(7'd100, 1'b0);
        collect(64, 250);
        tick(); tick();
        n_checks++; if (got_d.size() != 64 || addr_log.size() != 64) begin n_fail++; $display("FAIL clamp_count: got words=%0d reads=%0d expected 64 64", got_d.size(), addr_log.size()); end
        for (int i = 0; i < 64 && i < got_d.size() && i < addr_log.size(); i++) begin
            n_checks++;
            if (got_d[i] !== 16'h0100 + 16'(i) || got_l[i] !== (i == 63) || addr_log[i] !== 7'(i))
                begin n_fail++; $display("FAIL clamp_word[%0d]: got %h/%b addr %0d expected %h/%b addr %0d", i, got_d[i], got_l[i], addr_log[i], 16'h0100 + 16'(i), (i == 63), i); end
        end
    endtask

    task automatic test_busy_start_and_reset();
        bit ok;
        load_abcd(); addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        start_xfer(7'd2, 1'b0);
        bus.start = 1'b1; bus.count = 7'd4; bus.oldest_first = 1'b1;
        tick(); tick();
        bus.start = 1'b0;
        collect(2, 20);
        tick(); tick();
        n_checks++; if (got_d.size() != 2 || got_d[0] !== 16'h000D || got_d[1] !== 16'h000C)
            begin n_fail++; $display("FAIL busy_start_data: got %0d words expected 000D,000C", got_d.size()); end
        n_checks++; if (addr_log.size() != 2 || done_cnt != 1 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL busy_start_counts: got reads=%0d done=%0d busy=%b expected 2 1 0", addr_log.size(), done_cnt, bus.busy); end
        bus.out_ready = 1'b0;
        start_xfer(7'd4, 1'b1);
        wait_valid(10, ok);
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 7'd0 || bus.mem_read !== 1'b0 || bus.done !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid: got valid=%b data=%h last=%b busy=%b addr=%0d expected all 0", bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.mem_addr); end
        tick();
        rst = 1'b0;
        tick();
        bus.out_ready = 1'b1; addr_log.delete();
        start_xfer(7'd2, 1'b0);
        n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 7'd0) begin n_fail++; $display("FAIL reset_restart: got read=%b addr=%0d expected 1 0", bus.mem_read, bus.mem_addr); end
        collect(2, 20);
        tick(); tick();
        n_checks++; if (got_d.size() != 2 || got_d[0] !== 16'h000D || got_d[1] !== 16'h000C)
            begin n_fail++; $display("FAIL reset_restart_data: got %0d words expected 000D,000C", got_d.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] all_d [$];
        load_abcd(); addr_log.delete(); done_cnt = 0; bus.out_ready = 1'b1;
        bus.start = 1'b1; bus.count = 7'd2; bus.oldest_first = 1'b0;
        tick();
        collect(2, 20);
        all_d = got_d;
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", bus.done); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b read=%b expected 0 0", bus.busy, bus.mem_read); end
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 7'd0) begin n_fail++; $display("FAIL b2b_restart: got read=%b addr=%0d expected 1 0", bus.mem_read, bus.mem_addr); end
        collect(2, 20);
        all_d = {all_d, got_d};
        tick(); tick();
        n_checks++; if (all_d.size() != 4 || all_d[0] !== 16'h000D || all_d[1] !== 16'h000C || all_d[2] !== 16'h000D || all_d[3] !== 16'h000C)
            begin n_fail++; $display("FAIL b2b_data: got %0d words expected D,C,D,C", all_d.size()); end
        n_checks++; if (done_cnt != 2 || addr_log.size() != 4) begin n_fail++; $display("FAIL b2b_counts: got done=%0d reads=%0d expected 2 4", done_cnt, addr_log.size()); end
    endtask

    initial begin
        bus.start = 1'b0; bus.count = '0; bus.oldest_first = 1'b0;
        bus.out_ready = 1'b0; bus.mem_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        test_reset();
        test_newest();
        test_oldest();
        test_stall();
        test_zero_and_clamp();
        test_busy_start_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
